wb_stage: RTL and testbench



---
 rtl/wb_stage.sv | 155 +++++++++++++++
 tb/tb_wb_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- write-back stage of the five-stage RV32 pipeline.
//
// Selects the register-file write value from the ALU/EX result, data-memory
// read data (optionally byte/halfword extended) or PC+4 for link instructions,
// drives the register-file write port combinationally, and keeps a one-cycle
// registered copy of the write for the bypass network.
//
// Optional feature macro: WB_LOAD_EXT_EN
//   When defined, adds Load_Type (RV32 funct3) and Addr_Low (address [1:0])
//   inputs, and the WB_Ctrl=01 source becomes the lane-selected,
//   sign/zero-extended load value. When undefined, WB_Ctrl=01 passes RAM_Data.
//
// Ports:
//   clk        in   1   stage clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   RAM_Data   in  32   data-memory read data
//   PC_Plus4   in  32   PC+4 of the instruction in WB
//   EX_Data    in  32   ALU/EX result
//   WB_Ctrl    in   2   source select: 00 EX, 01 load, 10 PC+4, 11 zero
//   WB_Valid   in   1   instruction in WB is valid and writes rd
//   WB_Rd      in   5   destination register index
//   Load_Type  in   3   load funct3            (WB_LOAD_EXT_EN only)
//   Addr_Low   in   2   load address bits [1:0] (WB_LOAD_EXT_EN only)
//   WB_Data    out 32   selected write-back data, combinational
//   RF_We      out  1   register-file write enable, combinational
//   RF_Waddr   out  5   register-file write address (= WB_Rd)
//   Fwd_Data   out 32   registered WB_Data for bypass
//   Fwd_Rd     out  5   registered WB_Rd
//   Fwd_Valid  out  1   registered RF_We
//   Ctrl_Err   out  1   sticky: WB_Ctrl=11 seen with WB_Valid=1
// -----------------------------------------------------------------------------
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] RAM_Data,
  input  logic [31:0] PC_Plus4,
  input  logic [31:0] EX_Data,
  input  logic [1:0]  WB_Ctrl,
  input  logic        WB_Valid,
  input  logic [4:0]  WB_Rd,
`ifdef WB_LOAD_EXT_EN
  input  logic [2:0]  Load_Type,
  input  logic [1:0]  Addr_Low,
`endif
  output logic [31:0] WB_Data,
  output logic        RF_We,
  output logic [4:0]  RF_Waddr,
  output logic [31:0] Fwd_Data,
  output logic [4:0]  Fwd_Rd,
  output logic        Fwd_Valid,
  output logic        Ctrl_Err
);

  localparam int DATA_W = 32;

  localparam logic [1:0] SEL_EX   = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_ILL  = 2'b11;

`ifdef WB_LOAD_EXT_EN
  // Lane select plus sign/zero extension for sub-word loads. Halfword loads
  // use only addr_low[1]; LW and undefined funct3 codes pass the word through.
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [DATA_W-1:0] raw,
    input logic [2:0]        funct3,
    input logic [1:0]        addr_low
  );
    logic        [7:0]        byte_u;
    logic        [15:0]       half_u;
    logic signed [7:0]        byte_s;
    logic signed [15:0]       half_s;
    logic        [DATA_W-1:0] res;
    case (addr_low)
      2'd0:    byte_u = raw[7:0];
      2'd1:    byte_u = raw[15:8];
      2'd2:    byte_u = raw[23:16];
      default: byte_u = raw[31:24];
    endcase
    half_u = addr_low[1] ? raw[31:16] : raw[15:0];
    byte_s = signed'(byte_u);
    half_s = signed'(half_u);
    case (funct3)
      3'b000:  res = DATA_W'(byte_s);
      3'b100:  res = DATA_W'(byte_u);
      3'b001:  res = DATA_W'(half_s);
      3'b101:  res = DATA_W'(half_u);
      default: res = raw;
    endcase
    return res;
  endfunction
`endif

  logic [DATA_W-1:0] load_data_p0;
  logic [DATA_W-1:0] wb_data_p0;
  logic              rf_we_p0;

  logic [DATA_W-1:0] fwd_data_p1_d, fwd_data_p1_q;
  logic [4:0]        fwd_rd_p1_d,   fwd_rd_p1_q;
  logic              vld_p1_d,      vld_p1_q;
  logic              ctrl_err_d,    ctrl_err_q;

  // ---- Stage p0: combinational write-back select (independent of WB_Valid,
  // so an unknown valid never disturbs the data path) ----
  always_comb begin
`ifdef WB_LOAD_EXT_EN
    load_data_p0 = load_extend(RAM_Data, Load_Type, Addr_Low);
`else
    load_data_p0 = RAM_Data;
`endif
    wb_data_p0 = '0;
    case (WB_Ctrl)
      SEL_EX:   wb_data_p0 = EX_Data;
      SEL_LOAD: wb_data_p0 = load_data_p0;
      SEL_LINK: wb_data_p0 = PC_Plus4;
      default:  wb_data_p0 = '0;
    endcase
  end

  // x0 is hard-wired zero, so a write to it is suppressed here.
  assign rf_we_p0 = WB_Valid & (WB_Rd != 5'd0);

  assign WB_Data  = wb_data_p0;
  assign RF_We    = rf_we_p0;
  assign RF_Waddr = WB_Rd;

  always_comb begin
    fwd_data_p1_d = wb_data_p0;
    fwd_rd_p1_d   = WB_Rd;
    vld_p1_d      = rf_we_p0;
    ctrl_err_d    = ctrl_err_q | (WB_Valid & (WB_Ctrl == SEL_ILL));
  end

  // ---- Stage p0 -> p1: bypass register and sticky error flag ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_data_p1_q <= '0;
      fwd_rd_p1_q   <= '0;
      vld_p1_q      <= 1'b0;
      ctrl_err_q    <= 1'b0;
    end else begin
      fwd_data_p1_q <= fwd_data_p1_d;
      fwd_rd_p1_q   <= fwd_rd_p1_d;
      vld_p1_q      <= vld_p1_d;
      ctrl_err_q    <= ctrl_err_d;
    end
  end

  assign Fwd_Data  = fwd_data_p1_q;
  assign Fwd_Rd    = fwd_rd_p1_q;
  assign Fwd_Valid = vld_p1_q;
  assign Ctrl_Err  = ctrl_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
// Table-driven vectors for the select/write-enable/forward path, plus
// hand-written sequences for the sticky error, reset behaviour and (when
// WB_LOAD_EXT_EN is defined) load extension.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] RAM_Data, PC_Plus4, EX_Data;
  logic [1:0]  WB_Ctrl;
  logic        WB_Valid;
  logic [4:0]  WB_Rd;
`ifdef WB_LOAD_EXT_EN
  logic [2:0]  Load_Type;
  logic [1:0]  Addr_Low;
`endif
  logic [31:0] WB_Data;
  logic        RF_We;
  logic [4:0]  RF_Waddr;
  logic [31:0] Fwd_Data;
  logic [4:0]  Fwd_Rd;
  logic        Fwd_Valid;
  logic        Ctrl_Err;

  int n_checks = 0;
  int n_errors = 0;

  wb_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RAM_Data  (RAM_Data),
    .PC_Plus4  (PC_Plus4),
    .EX_Data   (EX_Data),
    .WB_Ctrl   (WB_Ctrl),
    .WB_Valid  (WB_Valid),
    .WB_Rd     (WB_Rd),
`ifdef WB_LOAD_EXT_EN
    .Load_Type (Load_Type),
    .Addr_Low  (Addr_Low),
`endif
    .WB_Data   (WB_Data),
    .RF_We     (RF_We),
    .RF_Waddr  (RF_Waddr),
    .Fwd_Data  (Fwd_Data),
    .Fwd_Rd    (Fwd_Rd),
    .Fwd_Valid (Fwd_Valid),
    .Ctrl_Err  (Ctrl_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  ctrl;
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] ram;
    logic [31:0] pc;
    logic [31:0] ex;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  vec_t vecs [8];

`ifdef WB_LOAD_EXT_EN
  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  al;
    logic [31:0] exp_data;
  } ext_t;
  ext_t evecs [8];
`endif

  // Watchdog: the bench has no open-ended waits, this only guards runaway time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            ctrl  v  rd     ram           pc            ex            exp_data      we
    vecs[0] = '{2'b00, 1, 5'd5,  32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
    vecs[1] = '{2'b01, 1, 5'd0,  32'h1234_5678, 32'h2222_2222, 32'h3333_3333, 32'h1234_5678, 0};
    vecs[2] = '{2'b10, 0, 5'd31, 32'h1111_1111, 32'h0000_1004, 32'h3333_3333, 32'h0000_1004, 0};
    vecs[3] = '{2'b11, 0, 5'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0};
    vecs[4] = '{2'b10, 1, 5'd1,  32'h0,         32'h8000_0000, 32'h0,         32'h8000_0000, 1};
    vecs[5] = '{2'b00, 1, 5'd31, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1};
    vecs[6] = '{2'b01, 1, 5'd12, 32'hA5A5_A5A5, 32'h4,         32'h8,         32'hA5A5_A5A5, 1};
    vecs[7] = '{2'b00, 1, 5'd0,  32'h0,         32'h0,         32'h7777_0000, 32'h7777_0000, 0};
`ifdef WB_LOAD_EXT_EN
    evecs[0] = '{3'b000, 2'd0, 32'hFFFF_FFA5};  // LB
    evecs[1] = '{3'b100, 2'd1, 32'h0000_00F0};  // LBU
    evecs[2] = '{3'b001, 2'd2, 32'hFFFF_8070};  // LH
    evecs[3] = '{3'b101, 2'd0, 32'h0000_F0A5};  // LHU
    evecs[4] = '{3'b010, 2'd3, 32'h8070_F0A5};  // LW
    evecs[5] = '{3'b001, 2'd3, 32'hFFFF_8070};  // LH ignores Addr_Low[0]
    evecs[6] = '{3'b000, 2'd3, 32'hFFFF_FF80};  // LB top lane
    evecs[7] = '{3'b011, 2'd1, 32'h8070_F0A5};  // undefined code
    Load_Type = 3'b010;
    Addr_Low  = 2'd0;
`endif

    rst_n = 1'b0; WB_Valid = 1'b1; WB_Rd = 5'd3; WB_Ctrl = 2'b11;
    RAM_Data = 32'h0; PC_Plus4 = 32'h0; EX_Data = 32'h0;

    // Reset state (valid traffic with illegal ctrl must not set Ctrl_Err)
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd_data",  Fwd_Data,  32'h0);
    chk("rst_fwd_rd",    {27'b0, Fwd_Rd}, 32'h0);
    chk("rst_fwd_valid", {31'b0, Fwd_Valid}, 32'h0);
    chk("rst_ctrl_err",  {31'b0, Ctrl_Err}, 32'h0);
    WB_Valid = 1'b0; WB_Ctrl = 2'b00;
    rst_n = 1'b1;

    // Source select stepping at 50 ns intervals
    RAM_Data = 32'd1; PC_Plus4 = 32'd2; EX_Data = 32'd3;
    WB_Ctrl = 2'b00; #1 chk("sel_ex",   WB_Data, 32'd3);
    #49 WB_Ctrl = 2'b01; #1 chk("sel_load", WB_Data, 32'd1);
    #49 WB_Ctrl = 2'b10; #1 chk("sel_link", WB_Data, 32'd2);

    // Table: combinational outputs, then the forwarded copy one edge later
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      WB_Ctrl = vecs[i].ctrl; WB_Valid = vecs[i].valid; WB_Rd = vecs[i].rd;
      RAM_Data = vecs[i].ram; PC_Plus4 = vecs[i].pc; EX_Data = vecs[i].ex;
      #1;
      chk($sformatf("v%0d_wb_data", i), WB_Data, vecs[i].exp_data);
      chk($sformatf("v%0d_rf_we", i),   {31'b0, RF_We}, {31'b0, vecs[i].exp_we});
      chk($sformatf("v%0d_rf_waddr", i), {27'b0, RF_Waddr}, {27'b0, vecs[i].rd});
      @(posedge clk); #1;
      chk($sformatf("v%0d_fwd_data", i),  Fwd_Data, vecs[i].exp_data);
      chk($sformatf("v%0d_fwd_rd", i),    {27'b0, Fwd_Rd}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d_fwd_valid", i), {31'b0, Fwd_Valid}, {31'b0, vecs[i].exp_we});
      chk($sformatf("v%0d_ctrl_err", i),  {31'b0, Ctrl_Err}, 32'h0);
    end

    // Sticky control error
    WB_Ctrl = 2'b11; WB_Valid = 1'b1; WB_Rd = 5'd4; EX_Data = 32'hCAFE_F00D;
    #1;
    chk("ill_wb_data", WB_Data, 32'h0);
    chk("ill_err_before_edge", {31'b0, Ctrl_Err}, 32'h0);
    @(posedge clk); #1;
    chk("ill_err_set", {31'b0, Ctrl_Err}, 32'h1);
    WB_Ctrl = 2'b00; WB_Valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ill_err_sticky", {31'b0, Ctrl_Err}, 32'h1);

    // X on WB_Valid does not disturb the data path
    WB_Valid = 1'bx; WB_Ctrl = 2'b00; EX_Data = 32'h0BAD_C0DE;
    #1 chk("x_valid_wb_data", WB_Data, 32'h0BAD_C0DE);
    WB_Valid = 1'b1; WB_Rd = 5'd9;
    @(posedge clk); #1;

    // Reset mid-stream for two edges with traffic applied
    WB_Ctrl = 2'b11;  // simultaneous error set must lose to reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_fwd_data",  Fwd_Data, 32'h0);
    chk("mid_rst_fwd_valid", {31'b0, Fwd_Valid}, 32'h0);
    chk("mid_rst_ctrl_err",  {31'b0, Ctrl_Err}, 32'h0);
    WB_Ctrl = 2'b00; EX_Data = 32'h5555_AAAA;
    #1;
    chk("mid_rst_wb_data", WB_Data, 32'h5555_AAAA);
    chk("mid_rst_rf_we",   {31'b0, RF_We}, 32'h1);
    @(posedge clk); #1;
    chk("mid_rst2_fwd_data",  Fwd_Data, 32'h0);
    chk("mid_rst2_fwd_rd",    {27'b0, Fwd_Rd}, 32'h0);
    chk("mid_rst2_fwd_valid", {31'b0, Fwd_Valid}, 32'h0);
    chk("mid_rst2_ctrl_err",  {31'b0, Ctrl_Err}, 32'h0);
    WB_Ctrl = 2'b10; PC_Plus4 = 32'h0000_0100;
    #1 chk("mid_rst2_wb_data", WB_Data, 32'h0000_0100);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_fwd_data",  Fwd_Data, 32'h0000_0100);
    chk("post_rst_fwd_rd",    {27'b0, Fwd_Rd}, 32'd9);
    chk("post_rst_fwd_valid", {31'b0, Fwd_Valid}, 32'h1);

`ifdef WB_LOAD_EXT_EN
    // Load extension
    RAM_Data = 32'h8070_F0A5; WB_Ctrl = 2'b01;
    for (int i = 0; i < 8; i++) begin
      Load_Type = evecs[i].lt; Addr_Low = evecs[i].al;
      #1 chk($sformatf("ext%0d_wb_data", i), WB_Data, evecs[i].exp_data);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
